// File: rtl/simon_game_ctrl.sv
// Round sequencer for the colour-memory game: captures a random sequence, kicks off
// playback, then checks the player's presses until a win, a wrong colour or a timeout.
module simon_game_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_ROUND      = 15,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        complete_display,
    input  logic        btn_valid,
    input  logic [1:0]  btn_colour,
    output logic        en_display,
    output logic [31:0] seq_out,
    output logic [3:0]  round_ctr,
    output logic        input_active,
    output logic        game_over,
    output logic        game_win,
    output logic [4:0]  score
);

    localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RMAX = 4'(MAX_ROUND);
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_START,
        SHOW_WAIT,
        INPUT,
        WIN,
        LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [31:0]   seq_q, seq_d;
    logic [3:0]    round_q, round_d;
    logic [4:0]    score_q, score_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          en_q, en_d;
    logic          act_q, act_d;
    logic          over_q, over_d;
    logic          win_q, win_d;
    logic [1:0]    exp_colour;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            seq_q   <= '0;
            round_q <= '0;
            score_q <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            en_q    <= 1'b0;
            act_q   <= 1'b0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seq_q   <= seq_d;
            round_q <= round_d;
            score_q <= score_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            en_q    <= en_d;
            act_q   <= act_d;
            over_q  <= over_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        round_d    = round_q;
        score_d    = score_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        lfsr_d     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : '0);
        exp_colour = seq_q[{idx_q, 1'b0} +: 2];

        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    seq_d   = lfsr_q;
                    round_d = '0;
                    score_d = '0;
                    state_d = SHOW_START;
                end
            end
            SHOW_START: state_d = SHOW_WAIT;
            SHOW_WAIT: begin
                if (complete_display) begin
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = INPUT;
                end
            end
            INPUT: begin
                // A press on the terminal timer cycle wins over the timeout.
                if (btn_valid) begin
                    if (btn_colour != exp_colour) begin
                        state_d = LOSE;
                    end else if (idx_q < round_q) begin
                        idx_d   = idx_q + 4'd1;
                        timer_d = '0;
                    end else begin
                        score_d = {1'b0, round_q} + 5'd1;
                        if (round_q == RMAX) begin
                            state_d = WIN;
                        end else begin
                            round_d = round_q + 4'd1;
                            state_d = SHOW_START;
                        end
                    end
                end else if (timer_q == TMAX) begin
                    state_d = LOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags are decoded from the next state so they line up with the state register.
        en_d   = (state_d == SHOW_START);
        act_d  = (state_d == INPUT);
        over_d = (state_d == WIN) || (state_d == LOSE);
        win_d  = (state_d == WIN);
    end

    assign en_display   = en_q;
    assign seq_out      = seq_q;
    assign round_ctr    = round_q;
    assign input_active = act_q;
    assign game_over    = over_q;
    assign game_win     = win_q;
    assign score        = score_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Randomized self-checking bench for simon_game_ctrl: a game-level model predicts
// scores, rounds, flags and the captured sequence from the drawn LFSR value.
module tb_simon_game_ctrl;

    localparam int          TO   = 20;
    localparam int          MX   = 3;
    localparam logic [31:0] SEED = 32'hACE1_1234;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, complete_display, btn_valid;
    logic [1:0]  btn_colour;
    logic        en_display, input_active, game_over, game_win;
    logic [31:0] seq_out;
    logic [3:0]  round_ctr;
    logic [4:0]  score;

    int          errors = 0;
    int          checks = 0;
    int          en_cnt = 0;
    logic [31:0] m_lfsr;
    logic [31:0] exp_seq;
    logic [31:0] prev_seq;
    bit          max_gap = 1'b0;

    always #5 clk = ~clk;

    simon_game_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .MAX_ROUND     (MX),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .complete_display(complete_display),
        .btn_valid       (btn_valid),
        .btn_colour      (btn_colour),
        .en_display      (en_display),
        .seq_out         (seq_out),
        .round_ctr       (round_ctr),
        .input_active    (input_active),
        .game_over       (game_over),
        .game_win        (game_win),
        .score           (score)
    );

    // Reference random source: the sequence is whatever this generator holds when start is taken.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic logic [1:0] colour_of(input int i);
        logic [31:0] s;
        s = exp_seq;
        return s[2*i +: 2];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (en_display) en_cnt++;
    endtask

    task automatic start_game();
        en_cnt  = 0;
        exp_seq = m_lfsr;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check("start_en", en_display, 1);
        check("start_round", round_ctr, 0);
        check("start_score", score, 0);
        check("start_over", game_over, 0);
        check("start_win", game_win, 0);
        check("start_seq", seq_out, exp_seq);
    endtask

    // Entered with en_display expected high; leaves the DUT in INPUT.
    task automatic show_phase(input int r);
        int d;
        check("show_en", en_display, 1);
        check("show_round", round_ctr, r);
        check("show_act", input_active, 0);
        step();
        check("wait_en", en_display, 0);
        d = $urandom_range(0, 4);
        repeat (d) begin
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b1;
            end else begin
                btn_valid  = 1'b1;
                btn_colour = 2'($urandom_range(0, 3));
            end
            step();
            start     = 1'b0;
            btn_valid = 1'b0;
            check("stray_en", en_display, 0);
            check("stray_act", input_active, 0);
            check("stray_round", round_ctr, r);
        end
        complete_display = 1'b1;
        step();
        complete_display = 1'b0;
        check("input_act", input_active, 1);
        check("input_seq", seq_out, exp_seq);
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid  = 1'b1;
        btn_colour = c;
        step();
        btn_valid  = 1'b0;
    endtask

    task automatic post_end(input int exp_score, input bit won);
        repeat (3) begin
            btn_valid        = 1'b1;
            btn_colour       = 2'($urandom_range(0, 3));
            complete_display = 1'($urandom_range(0, 1));
            step();
        end
        btn_valid        = 1'b0;
        complete_display = 1'b0;
        check("hold_over", game_over, 1);
        check("hold_win", game_win, won);
        check("hold_score", score, exp_score);
        check("hold_en", en_display, 0);
    endtask

    // kind 0: wrong colour at (fr,fi); kind 1: timeout at (fr,fi); fr > MX: play to a win.
    task automatic play(input int fr, input int fi, input int kind);
        int gap;
        start_game();
        for (int r = 0; r <= MX; r++) begin
            show_phase(r);
            for (int i = 0; i <= r; i++) begin
                if (r == fr && i == fi) begin
                    if (kind == 0) begin
                        press(colour_of(i) ^ 2'($urandom_range(1, 3)));
                    end else begin
                        repeat (TO - 1) step();
                        check("to_pre_act", input_active, 1);
                        step();
                    end
                    check("lose_over", game_over, 1);
                    check("lose_win", game_win, 0);
                    check("lose_act", input_active, 0);
                    check("lose_score", score, r);
                    post_end(r, 1'b0);
                    return;
                end
                gap = max_gap ? TO - 1 : $urandom_range(0, TO - 1);
                repeat (gap) begin
                    complete_display = 1'($urandom_range(0, 1));
                    step();
                end
                complete_display = 1'b0;
                check("gap_act", input_active, 1);
                press(colour_of(i));
                if (i < r) check("mid_act", input_active, 1);
            end
            check("round_score", score, r + 1);
            if (r == MX) begin
                check("win_over", game_over, 1);
                check("win_win", game_win, 1);
                check("win_act", input_active, 0);
                check("win_pulses", en_cnt, MX + 1);
                post_end(MX + 1, 1'b1);
                return;
            end
        end
    endtask

    initial begin
        int fr;
        rst_n            = 1'b0;
        start            = 1'b0;
        complete_display = 1'b0;
        btn_valid        = 1'b0;
        btn_colour       = 2'd0;
        #1;
        check("rst_en", en_display, 0);
        check("rst_seq", seq_out, 0);
        check("rst_round", round_ctr, 0);
        check("rst_act", input_active, 0);
        check("rst_over", game_over, 0);
        check("rst_win", game_win, 0);
        check("rst_score", score, 0);
        #22;
        rst_n = 1'b1;
        repeat (3) step();

        // Reset taken in the middle of INPUT clears outputs without a clock edge.
        start_game();
        show_phase(0);
        press(colour_of(0));
        show_phase(1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_act", input_active, 0);
        check("mid_rst_seq", seq_out, 0);
        check("mid_rst_round", round_ctr, 0);
        check("mid_rst_score", score, 0);
        repeat (2) step();
        rst_n  = 1'b1;
        en_cnt = 0;
        repeat (50) step();
        check("post_rst_pulses", en_cnt, 0);
        check("post_rst_act", input_active, 0);

        play(2, 1, 0);           // wrong colour at idx1 of round 2
        prev_seq = exp_seq;
        play(0, 0, 1);           // timeout with no press at all
        check("restart_newseq", 32'(seq_out != prev_seq), 1);
        play(1, 1, 1);           // timeout after an accepted press
        max_gap = 1'b1;
        play(MX + 1, 0, 0);      // win with every press on the last allowed cycle
        max_gap = 1'b0;
        play(MX + 1, 0, 0);

        for (int g = 0; g < 12; g++) begin
            fr = $urandom_range(0, MX + 1);
            play(fr, (fr > MX) ? 0 : $urandom_range(0, fr), $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
